// File: rtl/port_loader_if.sv
// rtl/port_loader_if.sv - memory input-port load bus: data, port select and load strobe
interface port_loader_if;
    logic [31:0] in0_1;
    logic        inport_sel;
    logic        inport_en;

    modport master (
        output in0_1,
        output inport_sel,
        output inport_en
    );

    modport slave (
        input in0_1,
        input inport_sel,
        input inport_en
    );
endinterface

// File: rtl/port_loader.sv
// rtl/port_loader.sv - synchronizes and debounces board inputs into single-cycle input-port loads
module port_loader #(
    parameter int SW_W            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw,
    input  logic            sel_sw,
    input  logic            btn_load,
    port_loader_if.master   port,
    output logic            busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DB_PRESS = 3'd1;
    localparam logic [2:0] LOAD     = 3'd2;
    localparam logic [2:0] WAIT_REL = 3'd3;
    localparam logic [2:0] DB_REL   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0] sw_m, sw_s;
    logic            sel_m, sel_s;
    logic            btn_m, btn_s;

    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic [31:0] in0_1_q;
    logic        sel_q;
    logic        en_q;

    // Two-flop synchronizers: the only logic that touches the raw board inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_m  <= '0;
            sw_s  <= '0;
            sel_m <= 1'b0;
            sel_s <= 1'b0;
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sw_m  <= sw;
            sw_s  <= sw_m;
            sel_m <= sel_sw;
            sel_s <= sel_m;
            btn_m <= btn_load;
            btn_s <= btn_m;
        end
    end

    // Debounce FSM next state; the counter restarts at 0 on each entry to a debounce state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = DB_PRESS;
                    cnt_next   = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = LOAD;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            LOAD: begin
                state_next = WAIT_REL;
            end
            WAIT_REL: begin
                if (!btn_s) begin
                    state_next = DB_REL;
                    cnt_next   = '0;
                end
            end
            DB_REL: begin
                if (btn_s) begin
                    state_next = WAIT_REL;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and registered status outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            en_q  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            en_q  <= (state_next == LOAD);
            busy  <= (state_next != IDLE);
        end
    end

    // Data and select are captured only on the edge entering LOAD and held until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in0_1_q <= '0;
            sel_q   <= 1'b0;
        end else if (state_next == LOAD && state != LOAD) begin
            in0_1_q <= 32'(sw_s);
            sel_q   <= sel_s;
        end
    end

    assign port.in0_1      = in0_1_q;
    assign port.inport_sel = sel_q;
    assign port.inport_en  = en_q;

endmodule

// File: tb/tb_port_loader.sv
// tb/tb_port_loader.sv - self-checking bench for port_loader with a strobe scoreboard
module tb_port_loader;

    logic       clk;
    logic       rst;
    logic [9:0] sw;
    logic       sel_sw;
    logic       btn_load;
    logic       busy;

    port_loader_if pif ();

    port_loader #(
        .SW_W           (10),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .sel_sw  (sel_sw),
        .btn_load(btn_load),
        .port    (pif.master),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    int          pulses;
    logic        prev_en;
    logic [32:0] exp_q[$];

    // Advance to the next falling edge and score any strobe seen there.
    task automatic tick();
        logic [32:0] exp_v;
        @(negedge clk);
        if (rst && pif.inport_en) begin
            pulses++;
            checks++;
            if (prev_en) begin
                failures++;
                $display("FAIL strobe_width inport_en high two cycles running, required one cycle");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe in0_1=%h sel=%b required no strobe",
                         pif.in0_1, pif.inport_sel);
            end else begin
                exp_v = exp_q.pop_front();
                if ({pif.in0_1, pif.inport_sel} !== exp_v) begin
                    failures++;
                    $display("FAIL strobe_data in0_1=%h sel=%b required in0_1=%h sel=%b",
                             pif.in0_1, pif.inport_sel, exp_v[32:1], exp_v[0]);
                end
            end
        end
        prev_en = rst & pif.inport_en;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [9:0] v, input logic s, input int hold, input int rel);
        sw     = v;
        sel_sw = s;
        exp_q.push_back({22'd0, v, s});
        btn_load = 1'b1;
        cycles(hold);
        btn_load = 1'b0;
        cycles(rel);
    endtask

    task automatic test_reset();
        rst = 1'b0; btn_load = 1'b0; sw = 10'h3FF; sel_sw = 1'b1;
        cycles(3);
        checks++;
        if ({pif.in0_1, pif.inport_sel, pif.inport_en, busy} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs in0_1=%h sel=%b en=%b busy=%b required all 0",
                     pif.in0_1, pif.inport_sel, pif.inport_en, busy);
        end
        sw = 10'h000; sel_sw = 1'b0;
        rst = 1'b1;
        cycles(5);
        checks++;
        if ({pif.in0_1, pif.inport_en, busy} !== 34'd0) begin
            failures++;
            $display("FAIL post_reset_idle in0_1=%h en=%b busy=%b required 0",
                     pif.in0_1, pif.inport_en, busy);
        end
    endtask

    task automatic test_press_bounce();
        logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   p0;
        p0 = pulses;
        sw = 10'h2A5; sel_sw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            btn_load = pat[i];
            tick();
        end
        btn_load = 1'b0;
        cycles(10);
        checks++;
        if (pulses != p0) begin
            failures++;
            $display("FAIL bounce_no_strobe pulses=%0d required %0d", pulses, p0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bounce_busy busy=%b required 0", busy);
        end
        checks++;
        if (pif.in0_1 !== 32'd0) begin
            failures++;
            $display("FAIL bounce_data in0_1=%h required 00000000", pif.in0_1);
        end
    endtask

    task automatic test_clean_press();
        int p0;
        int first_k;
        p0 = pulses;
        first_k = -1;
        sw = 10'h2A5; sel_sw = 1'b1;
        exp_q.push_back({32'h0000_02A5, 1'b1});
        btn_load = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (pif.inport_en && first_k < 0) first_k = k;
        end
        checks++;
        if (first_k != 7) begin
            failures++;
            $display("FAIL press_latency strobe after edge %0d required edge 7", first_k);
        end
        btn_load = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL release_busy_hold busy=%b required 1", busy);
                end
            end
            if (k == 7) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL release_busy_drop busy=%b required 0", busy);
                end
            end
        end
        checks++;
        if (pulses != p0 + 1) begin
            failures++;
            $display("FAIL clean_pulse_count pulses=%0d required %0d", pulses - p0, 1);
        end
    endtask

    task automatic test_held();
        int p0;
        p0 = pulses;
        sw = 10'h0F0; sel_sw = 1'b0;
        exp_q.push_back({32'h0000_00F0, 1'b0});
        btn_load = 1'b1;
        cycles(100);
        btn_load = 1'b0; tick();
        btn_load = 1'b0; tick();
        btn_load = 1'b1; tick();
        cycles(5);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL held_busy busy=%b required 1", busy);
        end
        btn_load = 1'b0;
        cycles(12);
        checks++;
        if (pulses != p0 + 1) begin
            failures++;
            $display("FAIL held_pulse_count pulses=%0d required 1", pulses - p0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL held_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_data_hold();
        press(10'h155, 1'b0, 10, 10);
        sw = 10'h3FF; sel_sw = 1'b1;
        for (int r = 0; r < 2; r++) begin
            cycles(50);
            checks++;
            if ({pif.in0_1, pif.inport_sel} !== {32'h0000_0155, 1'b0}) begin
                failures++;
                $display("FAIL data_hold in0_1=%h sel=%b required 00000155 sel=0",
                         pif.in0_1, pif.inport_sel);
            end
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        p0 = pulses;
        sw = 10'h0C3; sel_sw = 1'b1;
        btn_load = 1'b1;
        cycles(5);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_debounce_busy busy=%b required 1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({pif.in0_1, pif.inport_sel, pif.inport_en, busy} !== 35'd0) begin
            failures++;
            $display("FAIL async_reset in0_1=%h sel=%b en=%b busy=%b required all 0",
                     pif.in0_1, pif.inport_sel, pif.inport_en, busy);
        end
        btn_load = 1'b0;
        tick();
        rst = 1'b1;
        cycles(20);
        checks++;
        if (pulses != p0 || pif.in0_1 !== 32'd0) begin
            failures++;
            $display("FAIL reset_abort pulses=%0d in0_1=%h required 0 and 00000000",
                     pulses - p0, pif.in0_1);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses;
        press(10'h001, 1'b0, 10, 10);
        checks++;
        if ({pif.in0_1, pif.inport_sel} !== {32'h0000_0001, 1'b0}) begin
            failures++;
            $display("FAIL b2b_first in0_1=%h sel=%b required 00000001 sel=0",
                     pif.in0_1, pif.inport_sel);
        end
        press(10'h200, 1'b1, 10, 10);
        checks++;
        if ({pif.in0_1, pif.inport_sel} !== {32'h0000_0200, 1'b1}) begin
            failures++;
            $display("FAIL b2b_second in0_1=%h sel=%b required 00000200 sel=1",
                     pif.in0_1, pif.inport_sel);
        end
        checks++;
        if (pulses != p0 + 2) begin
            failures++;
            $display("FAIL b2b_pulse_count pulses=%0d required 2", pulses - p0);
        end
    endtask

    task automatic test_held_through_reset();
        int p0;
        p0 = pulses;
        sw = 10'h0AB; sel_sw = 1'b1;
        btn_load = 1'b1;
        rst = 1'b0;
        cycles(2);
        exp_q.push_back({32'h0000_00AB, 1'b1});
        rst = 1'b1;
        cycles(30);
        checks++;
        if (pulses != p0 + 1) begin
            failures++;
            $display("FAIL held_through_reset pulses=%0d required 1", pulses - p0);
        end
        btn_load = 1'b0;
        cycles(12);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL held_through_reset_idle busy=%b required 0", busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pulses   = 0;
        prev_en  = 1'b0;
        rst      = 1'b0;
        sw       = '0;
        sel_sw   = 1'b0;
        btn_load = 1'b0;
        test_reset();
        test_press_bounce();
        test_clean_press();
        test_held();
        test_data_hold();
        test_reset_mid();
        test_back_to_back();
        test_held_through_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_strobes outstanding=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/port_loader.md
Name: port_loader

Overview:
- Upstream front-end for the memory block's input-port registers.
- Conditions raw board inputs: a switch bank, a port-select switch and a load push-button.
- Synchronizes and debounces them, then drives the in0_1 / inport_sel / inport_en triple.
- Each debounced button press produces exactly one single-cycle inport_en strobe, with stable data and select.

Parameters:
- SW_W, 10, width of the raw switch bank (1..32); zero-extended onto in0_1.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles required to accept a press or release (>=1).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sw  input  SW_W  raw switch value, asynchronous to clk.
- sel_sw  input  1  raw port-select switch: 0 = inport0, 1 = inport1.
- btn_load  input  1  raw load button, active-high when pressed, bouncy.
- in0_1  output  32  captured data for the memory input ports: {zeros, sw}.
- inport_sel  output  1  captured port select.
- inport_en  output  1  one-cycle load strobe to the memory input registers.
- busy  output  1  high whenever FSM is not in IDLE.

Behaviour:
- Reset (rst low, async):
  - All state cleared immediately: sync flops, counter, FSM to IDLE.
  - Outputs: in0_1 = 0, inport_sel = 0, inport_en = 0, busy = 0.
  - Reset asserted mid-operation aborts any pending load; no strobe is emitted.
- Synchronizers: 2-flop synchronizer on each bit of sw, on sel_sw and on btn_load, giving sw_s, sel_s, btn_s. No other logic samples the raw inputs.
- FSM states: IDLE, DB_PRESS, LOAD, WAIT_REL, DB_REL. The counter is reset to 0 on every entry to DB_PRESS or DB_REL.
  - IDLE:
    - btn_s = 1 -> DB_PRESS.
    - otherwise stay.
  - DB_PRESS:
    - btn_s = 0 -> IDLE (glitch rejected).
    - cnt == DEBOUNCE_CYCLES-1 -> LOAD.
    - else cnt++.
  - LOAD:
    - Lasts exactly one cycle; unconditional -> WAIT_REL.
  - WAIT_REL:
    - btn_s = 0 -> DB_REL.
    - otherwise stay; a held button never re-triggers.
  - DB_REL:
    - btn_s = 1 -> WAIT_REL (release bounce rejected).
    - cnt == DEBOUNCE_CYCLES-1 -> IDLE.
    - else cnt++.
- Output registers:
  - On the edge that enters LOAD, in0_1 <= {(32-SW_W)'b0, sw_s} and inport_sel <= sel_s.
  - inport_en is a registered output: high only while the state is LOAD.
  - in0_1 and inport_sel therefore change on the same edge inport_en rises. They are valid throughout the strobe cycle and held until the next LOAD.
- busy is registered and equals (state != IDLE).
- Latency: with btn_load held high, inport_en is high in the cycle following edge N+3, where edge 1 is the first edge sampling raw btn_load high and N = DEBOUNCE_CYCLES.
- Boundary cases:
  - Switch or select changes outside the LOAD entry edge never affect outputs.
  - A press shorter than N stable synchronized cycles produces no strobe.
  - Button held through reset deassertion is treated as a fresh press: exactly one strobe once debounced.
  - The counter never wraps; it saturates by design at N-1 because a transition always occurs there.

Test Plan (DEBOUNCE_CYCLES = 4, SW_W = 10):
- Clean press: sw = 0x2A5, sel_sw = 1, btn_load high for 20 cycles then low -> single inport_en pulse in the cycle after edge 7, in0_1 = 0x000002A5, inport_sel = 1; busy returns to 0 four stable-low cycles after btn_s falls.
- Press bounce: btn_load pattern 1,1,0,1,1,0 then low -> no inport_en; FSM returns to IDLE, busy = 0; in0_1 stays 0.
- Held button: btn_load high for 100 cycles -> exactly one inport_en pulse; release bounce 0,0,1 during WAIT_REL -> no second pulse.
- Data hold: after load of sw = 0x155 with sel 0, change sw to 0x3FF and sel_sw to 1 with no press -> in0_1 = 0x00000155 and inport_sel = 0 held indefinitely.
- Reset mid-debounce: assert rst low during DB_PRESS (cnt = 2) -> outputs immediately 0, busy = 0; release rst with btn low -> no strobe ever.
- Back-to-back: two full press/release cycles, sw = 0x001 then 0x200, sel 0 then 1 -> two pulses; in0_1 = 0x00000001 / sel 0, then 0x00000200 / sel 1.
